pager_preset_seq: RTL and testbench

PAGER_PRESET_SEQ -- requirements
Module: pager_preset_seq

---
 rtl/pager_preset_seq.sv | 120 ++++++++++++
 tb/tb_pager_preset_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pager_preset_seq.sv
// Pager preset sequencer: replays up to eight preloaded xxF7 pager writes on request and
// merges them with live Z80 xxF7 writes onto one registered write port. The Z80 always wins.
module pager_preset_seq #(
  parameter int unsigned GAP = 2
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        z_f7_wr,
  input  logic [15:0] z_a,
  input  logic [7:0]  z_d,
  input  logic        ld_stb,
  input  logic [2:0]  ld_idx,
  input  logic [12:0] ld_ent,
  input  logic        start,
  output logic        f7_wr,
  output logic [15:0] f7_a,
  output logic [7:0]  f7_d,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_GAP,
    ST_FIN
  } state_t;

  localparam logic [3:0] GAP_LD = 4'(GAP);

  state_t      state;
  logic [2:0]  idx;
  logic [3:0]  gap_cnt;
  logic [7:0]  tbl_en;
  logic [11:0] tbl_fld [8];

  logic        ld_ok;
  logic        seq_issue;
  logic [11:0] cur_fld;

  assign ld_ok     = ld_stb & ~busy;
  assign cur_fld   = tbl_fld[idx];
  assign seq_issue = (state == ST_ISSUE) && !z_f7_wr;

  // Pager port address: {window, 11, port code, 11, F7}
  function automatic logic [15:0] enc_addr(input logic [11:0] fld);
    return {fld[11:10], 2'b11, fld[9:8], 2'b11, 8'hF7};
  endfunction

  // Window/port/data fields carry no reset; a cleared enable hides stale contents.
  always_ff @(posedge fclk) begin
    if (ld_ok) tbl_fld[ld_idx] <= ld_ent[11:0];
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= 3'd0;
      gap_cnt <= 4'd0;
      tbl_en  <= 8'h00;
      f7_wr   <= 1'b0;
      f7_a    <= 16'h0000;
      f7_d    <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (ld_ok) tbl_en[ld_idx] <= ld_ent[12];

      // Output stage: the sequencer only issues in cycles with no Z80 write, so no collision.
      f7_wr <= z_f7_wr | seq_issue;
      if (z_f7_wr) begin
        f7_a <= z_a;
        f7_d <= z_d;
      end else if (seq_issue) begin
        f7_a <= enc_addr(cur_fld);
        f7_d <= cur_fld[7:0];
      end

      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx   <= 3'd0;
            busy  <= 1'b1;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (tbl_en[idx])        state <= ST_ISSUE;
          else if (idx == 3'd7)   state <= ST_FIN;
          else                    idx   <= idx + 3'd1;
        end
        ST_ISSUE: begin
          if (!z_f7_wr) begin
            gap_cnt <= GAP_LD;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (idx == 3'd7) begin
            state <= ST_FIN;
          end else begin
            idx   <= idx + 3'd1;
            state <= ST_SCAN;
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pager_preset_seq.sv
// Bench for pager_preset_seq: a fixed stimulus trace (directed segments plus random traffic)
// is turned into an expected output trace by a schedule model, then compared every cycle.
module tb_pager_preset_seq;

  localparam int G  = 2;
  localparam int N  = 1600;
  localparam int NX = N + 64;

  logic        fclk = 1'b0;
  logic        rst = 1'b1;
  logic        z_f7_wr = 1'b0;
  logic [15:0] z_a = 16'h0;
  logic [7:0]  z_d = 8'h0;
  logic        ld_stb = 1'b0;
  logic [2:0]  ld_idx = 3'h0;
  logic [12:0] ld_ent = 13'h0;
  logic        start = 1'b0;
  logic        f7_wr;
  logic [15:0] f7_a;
  logic [7:0]  f7_d;
  logic        busy;
  logic        done;

  pager_preset_seq #(.GAP(G)) dut (
    .fclk(fclk), .rst(rst), .z_f7_wr(z_f7_wr), .z_a(z_a), .z_d(z_d),
    .ld_stb(ld_stb), .ld_idx(ld_idx), .ld_ent(ld_ent), .start(start),
    .f7_wr(f7_wr), .f7_a(f7_a), .f7_d(f7_d), .busy(busy), .done(done)
  );

  always #5 fclk = ~fclk;

  // stimulus trace, one entry per cycle
  bit          s_rst [N];
  bit          s_zwr [N];
  bit          s_ld  [N];
  bit          s_start [N];
  logic [15:0] s_za [N];
  logic [7:0]  s_zd [N];
  logic [2:0]  s_li [N];
  logic [12:0] s_le [N];

  // expected outputs per cycle
  bit          e_wr [NX];
  bit          e_busy [NX];
  bit          e_done [NX];
  bit          e_ad [NX];
  logic [15:0] e_a [NX];
  logic [7:0]  e_d [NX];

  // observed outputs per cycle
  bit          a_wr [N];
  bit          a_busy [N];
  bit          a_done [N];
  logic [15:0] a_a [N];
  logic [7:0]  a_d [N];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = -1;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, want);
  endtask

  task automatic put_ld(input int k, input int i, input logic [12:0] ent);
    s_ld[k] = 1'b1;
    s_li[k] = 3'(i);
    s_le[k] = ent;
  endtask

  function automatic int cnt_wr(input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) if (a_wr[j]) n++;
    return n;
  endfunction

  function automatic int cnt_done(input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) if (a_done[j]) n++;
    return n;
  endfunction

  // Schedule model: a start at cycle k scans from k+1; each skipped entry costs one cycle;
  // an enabled entry is issued in the first cycle after its scan cycle without a Z80 write,
  // appears one cycle later, and is followed by G+1 gap cycles before the next scan.
  task automatic build_model();
    logic [12:0] tbl [8];
    int r, c, s;
    for (int i = 0; i < 8; i++) tbl[i] = 13'h0;
    for (int j = 0; j < NX; j++) begin
      e_wr[j] = 0; e_busy[j] = 0; e_done[j] = 0; e_ad[j] = 0; e_a[j] = 16'h0; e_d[j] = 8'h0;
    end
    for (int k = 0; k < N; k++) begin
      if (s_rst[k]) begin
        for (int i = 0; i < 8; i++) tbl[i][12] = 1'b0;
        for (int j = k; j <= k + 1; j++) begin
          e_wr[j] = 0; e_busy[j] = 0; e_done[j] = 0; e_ad[j] = 1; e_a[j] = 16'h0; e_d[j] = 8'h0;
        end
        continue;
      end
      if (s_zwr[k]) begin
        e_wr[k+1] = 1; e_ad[k+1] = 1; e_a[k+1] = s_za[k]; e_d[k+1] = s_zd[k];
      end
      if (s_ld[k] && !e_busy[k]) tbl[s_li[k]] = s_le[k];
      if (s_start[k] && !e_busy[k]) begin
        r = k + 1;
        while (r < N && !s_rst[r]) r++;
        c = k + 1;
        for (int i = 0; i < 8; i++) begin
          if (tbl[i][12]) begin
            s = c + 1;
            while (s < N && s_zwr[s]) s++;
            if (s + 1 < r) begin
              e_wr[s+1] = 1; e_ad[s+1] = 1;
              e_a[s+1]  = {tbl[i][11:10], 2'b11, tbl[i][9:8], 2'b11, 8'hF7};
              e_d[s+1]  = tbl[i][7:0];
            end
            c = s + G + 2;
          end else begin
            c++;
          end
        end
        for (int j = k + 1; j <= c && j < r; j++) e_busy[j] = 1;
        if (c + 1 < r) e_done[c+1] = 1;
      end
    end
  endtask

  // per-cycle compare against the model
  always @(negedge fclk) begin
    if (cyc >= 0 && cyc < N) begin
      a_wr[cyc] = f7_wr; a_busy[cyc] = busy; a_done[cyc] = done;
      a_a[cyc] = f7_a; a_d[cyc] = f7_d;
      check("f7_wr", cyc, 32'(f7_wr), 32'(e_wr[cyc]));
      check("busy", cyc, 32'(busy), 32'(e_busy[cyc]));
      check("done", cyc, 32'(done), 32'(e_done[cyc]));
      if (e_ad[cyc]) begin
        check("f7_a", cyc, 32'(f7_a), 32'(e_a[cyc]));
        check("f7_d", cyc, 32'(f7_d), 32'(e_d[cyc]));
      end
    end
  end

  localparam int TZ = 2, TA = 24, TB = 50, TC = 80, TE = 110, TE2 = 140, TF = 180, TF2 = 210;

  initial begin
    logic [15:0] win_a [4];
    win_a[0] = 16'h3FF7; win_a[1] = 16'h7FF7; win_a[2] = 16'hBFF7; win_a[3] = 16'hFFF7;

    for (int k = 0; k < N; k++) begin
      s_za[k] = 16'h0; s_zd[k] = 8'h0; s_li[k] = 3'h0; s_le[k] = 13'h0;
    end
    s_rst[0] = 1'b1;
    // all entries disabled straight out of reset
    s_start[TZ] = 1'b1;
    // only entry 0 enabled: window 0, port 01, data FA
    for (int i = 0; i < 8; i++) put_ld(14 + i, i, (i == 0) ? 13'h11FA : 13'h0000);
    s_start[TA] = 1'b1;
    // entries 0..3 enabled for windows 0..3, port 11
    for (int i = 0; i < 8; i++) put_ld(40 + i, i, (i < 4) ? {1'b1, 2'(i), 2'b11, 8'(16 + i)} : 13'h0000);
    s_start[TB] = 1'b1;
    // Z80 write lands in the cycle entry 1 would be issued
    s_start[TC] = 1'b1;
    s_zwr[TC+7] = 1'b1; s_za[TC+7] = 16'h1234; s_zd[TC+7] = 8'h5A;
    // load and restart attempts while busy
    s_start[TE] = 1'b1;
    put_ld(TE + 5, 0, 13'h1000);
    s_start[TE+6] = 1'b1;
    put_ld(TE + 7, 5, 13'h1FFF);
    s_start[TE2] = 1'b1;
    // reset between the second and third write
    s_start[TF] = 1'b1;
    s_rst[TF+10] = 1'b1;
    s_start[TF2] = 1'b1;
    // random traffic
    for (int k = 230; k < N - 100; k++) begin
      s_rst[k]   = ($urandom_range(0, 299) == 0);
      s_zwr[k]   = ($urandom_range(0, 3) == 0);
      s_za[k]    = 16'($urandom);
      s_zd[k]    = 8'($urandom);
      s_ld[k]    = ($urandom_range(0, 5) == 0);
      s_li[k]    = 3'($urandom);
      s_le[k]    = 13'($urandom);
      if ($urandom_range(0, 3) != 0) s_le[k][12] = 1'b1;
      s_start[k] = ($urandom_range(0, 19) == 0);
    end

    build_model();

    for (int k = 0; k < N; k++) begin
      @(posedge fclk);
      #1;
      rst = s_rst[k]; z_f7_wr = s_zwr[k]; z_a = s_za[k]; z_d = s_zd[k];
      ld_stb = s_ld[k]; ld_idx = s_li[k]; ld_ent = s_le[k]; start = s_start[k];
      cyc = k;
    end
    @(posedge fclk);
    #1;
    rst = 1'b0; z_f7_wr = 1'b0; ld_stb = 1'b0; start = 1'b0;
    cyc = N;
    repeat (2) @(posedge fclk);

    // hand-derived expectations for the directed segments
    check("rst_wr", 0, 32'(a_wr[0]), 32'd0);
    check("rst_a", 1, 32'(a_a[1]), 32'h0);
    check("rst_busy", 1, 32'(a_busy[1]), 32'd0);
    check("alldis_busy", TZ + 9, 32'(a_busy[TZ+9]), 32'd1);
    check("alldis_done", TZ + 10, 32'(a_done[TZ+10]), 32'd1);
    check("alldis_nwr", TZ, 32'(cnt_wr(TZ, TZ + 12)), 32'd0);
    check("e0_wr", TA + 3, 32'(a_wr[TA+3]), 32'd1);
    check("e0_a", TA + 3, 32'(a_a[TA+3]), 32'h37F7);
    check("e0_d", TA + 3, 32'(a_d[TA+3]), 32'hFA);
    check("e0_nwr", TA, 32'(cnt_wr(TA, TA + 16)), 32'd1);
    check("e0_done", TA + 14, 32'(a_done[TA+14]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("win_wr", TB + 3 + 5 * i, 32'(a_wr[TB+3+5*i]), 32'd1);
      check("win_a", TB + 3 + 5 * i, 32'(a_a[TB+3+5*i]), 32'(win_a[i]));
    end
    check("win_done", TB + 26, 32'(a_done[TB+26]), 32'd1);
    check("z80_a", TC + 8, 32'(a_a[TC+8]), 32'h1234);
    check("z80_d", TC + 8, 32'(a_d[TC+8]), 32'h5A);
    check("defer_wr", TC + 9, 32'(a_wr[TC+9]), 32'd1);
    check("defer_a", TC + 9, 32'(a_a[TC+9]), 32'h7FF7);
    check("busyld_nwr", TE, 32'(cnt_wr(TE, TE + 29)), 32'd4);
    check("busyld_ndone", TE, 32'(cnt_done(TE, TE + 29)), 32'd1);
    check("busyld_done", TE + 26, 32'(a_done[TE+26]), 32'd1);
    check("busyld_d0", TE2 + 3, 32'(a_d[TE2+3]), 32'h10);
    check("busyld_nwr2", TE2, 32'(cnt_wr(TE2, TE2 + 30)), 32'd4);
    check("abort_pre", TF, 32'(cnt_wr(TF, TF + 9)), 32'd2);
    check("abort_busy", TF + 10, 32'(a_busy[TF+10]), 32'd0);
    check("abort_a", TF + 10, 32'(a_a[TF+10]), 32'h0);
    check("abort_nwr", TF + 10, 32'(cnt_wr(TF + 10, TF2 - 1)), 32'd0);
    check("abort_ndone", TF, 32'(cnt_done(TF, TF2 - 1)), 32'd0);
    check("cleared_nwr", TF2, 32'(cnt_wr(TF2, TF2 + 15)), 32'd0);
    check("cleared_done", TF2 + 10, 32'(a_done[TF2+10]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
